// File: rtl/layer_ctrl_pkg.sv
// Shared types and width helpers for the fully-connected layer controller.
// Imported by layer_ctrl and its lane/group/load counters.
package layer_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN,
    OUTPUT
  } state_t;

  function automatic int aw(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/layer_ctrl_wrap_counter.sv
// Modulo-MAX counter with a terminal-count flag.
// Used for the element, group and lane indices of layer_ctrl.
module wrap_counter
  import layer_ctrl_pkg::*;
#(
  parameter int MAX = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic [aw(MAX)-1:0]   count,
  output logic                 last
);

  localparam int CW = aw(MAX);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign last  = (count_q == CW'(MAX - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = last ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/layer_ctrl.sv
// Load / compute / drain / output sequencer for one FC layer.
// Drives vector RAM and weight ROM addresses plus MAC strobes.
module layer_ctrl
  import layer_ctrl_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 8,
  parameter int P = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    x_wr_en,
  output logic [aw(M)-1:0]        x_addr,
  output logic [aw(M*N/P)-1:0]    w_addr,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [aw(P)-1:0]        out_sel
);

  localparam int WW = aw(M*N/P);
  localparam int G  = N / P;

  state_t state_q;
  state_t state_d;

  logic              k_en;
  logic              g_en;
  logic              s_en;
  logic              k_last;
  logic              g_last;
  logic              s_last;
  logic [aw(M)-1:0]  k_cnt;
  logic [aw(G)-1:0]  g_cnt;
  logic [aw(P)-1:0]  s_cnt;
  logic              en_q;
  logic              clr_q;

  wrap_counter #(.MAX(M)) u_k (
    .clk   (clk),
    .reset (reset),
    .en    (k_en),
    .count (k_cnt),
    .last  (k_last)
  );

  wrap_counter #(.MAX(G)) u_g (
    .clk   (clk),
    .reset (reset),
    .en    (g_en),
    .count (g_cnt),
    .last  (g_last)
  );

  wrap_counter #(.MAX(P)) u_s (
    .clk   (clk),
    .reset (reset),
    .en    (s_en),
    .count (s_cnt),
    .last  (s_last)
  );

  always_comb begin
    state_d = state_q;
    k_en    = 1'b0;
    g_en    = 1'b0;
    s_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = LOAD;
      end
      LOAD: begin
        if (in_valid) begin
          k_en = 1'b1;
          if (k_last) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        k_en = 1'b1;
        if (k_last) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          s_en = 1'b1;
          if (s_last) begin
            g_en    = 1'b1;
            state_d = g_last ? LOAD : COMPUTE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes trail their address by the 1-cycle RAM/ROM read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q  <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      en_q  <= (state_q == COMPUTE);
      clr_q <= (state_q == COMPUTE) && (k_cnt == '0);
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign x_wr_en   = in_valid && in_ready;
  assign x_addr    = k_cnt;
  assign w_addr    = (state_q == COMPUTE)
                   ? WW'(32'(g_cnt) * M + 32'(k_cnt))
                   : '0;
  assign mac_en    = en_q;
  assign mac_clr   = clr_q;
  assign out_valid = (state_q == OUTPUT);
  assign out_sel   = s_cnt;

endmodule

// File: tb/tb_layer_ctrl.sv
// Self-checking bench: P=1 and P=2 controllers driven side by side
// through a behavioural datapath and a dot-product scoreboard.
module tb_layer_ctrl;

  localparam int M = 4;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;

  logic       ir0, we0, clr0, en0, ov0;
  logic [1:0] xa0;
  logic [4:0] wa0;
  logic [0:0] sel0;
  logic       ir1, we1, clr1, en1, ov1;
  logic [1:0] xa1;
  logic [3:0] wa1;
  logic [0:0] sel1;

  layer_ctrl #(.M(M), .N(N), .P(1)) u_p1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (ir0),
    .x_wr_en   (we0),
    .x_addr    (xa0),
    .w_addr    (wa0),
    .mac_clr   (clr0),
    .mac_en    (en0),
    .out_valid (ov0),
    .out_ready (out_ready),
    .out_sel   (sel0)
  );

  layer_ctrl #(.M(M), .N(N), .P(2)) u_p2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (ir1),
    .x_wr_en   (we1),
    .x_addr    (xa1),
    .w_addr    (wa1),
    .mac_clr   (clr1),
    .mac_en    (en1),
    .out_valid (ov1),
    .out_ready (out_ready),
    .out_sel   (sel1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int first_y = -1;
  bit wmode = 1'b1;
  bit seqmode = 1'b1;

  int ram [2][M];
  int cur [2][M];
  int expv [2][N];
  int acc [2][2];
  int wr [2][2];
  int xr [2];
  logic [31:0] px [2];
  logic [31:0] pw [2];
  int macs [2];
  int elem [2];
  int outs [2];
  int out_total [2];
  int trig [2];
  bit busy [2];
  bit rst_seen [2];
  bit pov [2];
  bit pordy [2];
  logic [31:0] psel [2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic string tg(input int d, input string s);
    return $sformatf("dut%0d_%s", d, s);
  endfunction

  function automatic int relu(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int wt(input int n, input int k);
    return wmode ? 1 : ((n * 5 + k * 3 + 1) % 7) - 3;
  endfunction

  // Lane l of a P-lane layer holds neuron g*P+l at address g*M+k.
  function automatic int rom(input int pl, input int l, input logic [31:0] a);
    int n;
    if ((^a) === 1'bx) return 0;
    n = (int'(a) / M) * pl + l;
    if (n >= N) return 0;
    return wt(n, int'(a) % M);
  endfunction

  task automatic newvec(input int d);
    for (int k = 0; k < M; k++)
      cur[d][k] = seqmode ? k + 1 : int'($urandom_range(15, 0)) - 8;
  endtask

  task automatic mon(input int d, input int pl, input logic iv,
                     input logic ir, input logic we,
                     input logic [31:0] xa, input logic [31:0] wa,
                     input logic clr, input logic en, input logic ov,
                     input logic ordy, input logic [31:0] sel,
                     input logic rst);
    int got;
    int idx;
    int g;
    int s;
    if (!rst) begin
      chk(tg(d, "rst_in_ready"), ir, 0);
      chk(tg(d, "rst_out_valid"), ov, 0);
      chk(tg(d, "rst_mac_en"), en, 0);
      busy[d] = 0;
      elem[d] = 0;
      outs[d] = 0;
      macs[d] = 0;
      out_total[d] = 0;
      pov[d] = 0;
      pordy[d] = 0;
      rst_seen[d] = 1;
      for (int l = 0; l < 2; l++) acc[d][l] = 0;
      newvec(d);
      return;
    end
    chk(tg(d, "in_ready"), ir, !rst_seen[d] && !busy[d]);
    rst_seen[d] = 0;
    chk(tg(d, "x_wr_en"), we, iv && ir);
    if (!busy[d]) chk(tg(d, "idle_out_valid"), ov, 0);
    chk(tg(d, "mac_quiet"), en && (ir || ov), 0);
    if (pov[d] && !pordy[d]) begin
      chk(tg(d, "stall_valid"), ov, 1);
      chk(tg(d, "stall_sel"), sel, psel[d]);
    end
    if (ov && !pov[d]) chk(tg(d, "latency"), cyc - trig[d], M + 2);
    if (ov) begin
      chk(tg(d, "out_sel"), sel, outs[d] % pl);
      if (ordy) begin
        got = (sel < pl) ? relu(acc[d][int'(sel)]) : -1;
        chk(tg(d, "result"), got, expv[d][outs[d]]);
        if (d == 0 && first_y < 0) first_y = got;
        outs[d]++;
        if (outs[d] % pl == 0) trig[d] = cyc;
        if (outs[d] == N) begin
          busy[d] = 0;
          outs[d] = 0;
          out_total[d]++;
        end
      end
    end
    if (en) begin
      idx = macs[d] % M;
      g = (macs[d] / M) % (N / pl);
      chk(tg(d, "mac_clr"), clr, idx == 0);
      chk(tg(d, "w_addr"), pw[d], g * M + idx);
      chk(tg(d, "x_addr_rd"), px[d], idx);
      for (int l = 0; l < pl; l++)
        acc[d][l] = (clr ? 0 : acc[d][l]) + xr[d] * wr[d][l];
      macs[d]++;
    end else begin
      chk(tg(d, "clr_alone"), clr, 0);
    end
    px[d] = xa;
    pw[d] = wa;
    xr[d] = (xa < M) ? ram[d][int'(xa)] : 0;
    for (int l = 0; l < pl; l++) wr[d][l] = rom(pl, l, wa);
    if (iv && ir) begin
      chk(tg(d, "x_addr_wr"), xa, elem[d]);
      if (xa < M) ram[d][int'(xa)] = cur[d][elem[d]];
      elem[d]++;
      if (elem[d] == M) begin
        for (int n = 0; n < N; n++) begin
          s = 0;
          for (int k = 0; k < M; k++) s += wt(n, k) * cur[d][k];
          expv[d][n] = relu(s);
        end
        busy[d] = 1;
        trig[d] = cyc;
        elem[d] = 0;
        newvec(d);
      end
    end
    pov[d] = ov;
    pordy[d] = ordy;
    psel[d] = sel;
  endtask

  always @(negedge clk)
    mon(0, 1, in_valid, ir0, we0, 32'(xa0), 32'(wa0), clr0, en0,
        ov0, out_ready, 32'(sel0), reset);

  always @(negedge clk)
    mon(1, 2, in_valid, ir1, we1, 32'(xa1), 32'(wa1), clr1, en1,
        ov1, out_ready, 32'(sel1), reset);

  task automatic zero_chk(input string tag);
    chk({tag, "_p1_in_ready"}, ir0, 0);
    chk({tag, "_p1_x_wr_en"}, we0, 0);
    chk({tag, "_p1_x_addr"}, xa0, 0);
    chk({tag, "_p1_w_addr"}, wa0, 0);
    chk({tag, "_p1_mac"}, {clr0, en0}, 0);
    chk({tag, "_p1_out"}, {ov0, sel0}, 0);
    chk({tag, "_p2_in_ready"}, ir1, 0);
    chk({tag, "_p2_x_wr_en"}, we1, 0);
    chk({tag, "_p2_x_addr"}, xa1, 0);
    chk({tag, "_p2_w_addr"}, wa1, 0);
    chk({tag, "_p2_mac"}, {clr1, en1}, 0);
    chk({tag, "_p2_out"}, {ov1, sel1}, 0);
  endtask

  task automatic release_chk(input string tag);
    @(posedge clk);
    #1 reset = 1'b1;
    chk({tag, "_idle_p1"}, ir0, 0);
    chk({tag, "_idle_p2"}, ir1, 0);
    @(posedge clk);
    #1;
    chk({tag, "_load_p1"}, {ir0, xa0}, 3'b100);
    chk({tag, "_load_p2"}, {ir1, xa1}, 3'b100);
  endtask

  task automatic wait_total(input int d, input int tgt, input int budget,
                            input string tag);
    int n = 0;
    while (out_total[d] < tgt && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, out_total[d] >= tgt, 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((busy[0] || busy[1]) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, {busy[0], busy[1]}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [0:0] s_hold;
    logic [4:0] w_hold;
    repeat (3) @(posedge clk);
    #1 zero_chk("por");
    release_chk("por");

    in_valid = 1'b1;
    out_ready = 1'b1;
    wait_total(0, 1, 200, "phaseA_done");
    chk("phaseA_first_y", first_y, 10);
    in_valid = 1'b0;
    wait_idle(300, "phaseA_drain");

    wmode = 1'b0;
    seqmode = 1'b0;
    repeat (800) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(1, 0));
      out_ready = 1'($urandom_range(1, 0));
    end
    chk("phaseB_progress_p1", out_total[0] >= 2, 1);
    chk("phaseB_progress_p2", out_total[1] >= 2, 1);

    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (ov0 !== 1'b1 && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    chk("stall_reach", ov0, 1);
    out_ready = 1'b0;
    s_hold = sel0;
    w_hold = wa0;
    repeat (20) begin
      @(negedge clk);
      chk("stall_ov", ov0, 1);
      chk("stall_sel", sel0, s_hold);
      chk("stall_waddr", wa0, w_hold);
      chk("stall_mac_en", en0, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;

    n = 0;
    while (outs[0] == 1 && n < 300) begin
      @(posedge clk);
      n++;
    end
    n = 0;
    while (outs[0] != 1 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("midreset_reach", outs[0], 1);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1 zero_chk("midreset");
    @(posedge clk);
    release_chk("midreset");

    wait_total(0, 3, 600, "b2b_vectors_p1");
    in_valid = 1'b0;
    wait_idle(300, "final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_ctrl.md
# layer_ctrl

Sequencing controller for one fully-connected layer of the `net_*` pipeline. It loads an M-element input vector into the layer's vector memory and then walks the weight ROMs group by group, P output neurons at a time. It drives the MAC lanes' clear/enable strobes and then serialises the P lane results onto the layer's output handshake. It owns only control: the datapath (vector RAM, weight ROMs, MACs, ReLU, output mux) consumes its addresses and strobes.

## Interface
- `M`, 4: input vector length (≥2)
- `N`, 8: output vector length; N % P == 0
- `P`, 1: parallel MAC lanes (≥1)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset asserted)
- `in_valid`  in  1  upstream element available
- `in_ready`  out  1  controller accepts an element (LOAD only)
- `x_wr_en`  out  1  write strobe to vector RAM = in_valid && in_ready
- `x_addr`  out  $clog2(M)  vector RAM address (write in LOAD, read in COMPUTE)
- `w_addr`  out  $clog2(M*N/P)  address into every lane's weight ROM
- `mac_clr`  out  1  lanes load product instead of accumulating
- `mac_en`  out  1  lanes update accumulator
- `out_valid`  out  1  result on `out_sel` lane is presented
- `out_ready`  in  1  downstream accepts
- `out_sel`  out  $clog2(P) (min 1)  lane selected by output mux

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN, OUTPUT.
- IDLE: entered on reset; leaves for LOAD on the first clock after reset release. All outputs 0.
- LOAD: `in_ready`=1; `x_addr`=load count k. Each handshake writes element k and increments k. On accepting element M-1, k wraps to 0 and the state goes to COMPUTE with group g=0.
- COMPUTE, M cycles: `x_addr`=k, `w_addr`=g·M+k, k=0..M-1. ROM/RAM read latency is 1 cycle, so the strobes are delayed one cycle from their address: `mac_en`=1 in the cycle after each address, and `mac_clr`=1 together with the `mac_en` belonging to k=0. After k=M-1, the state goes to DRAIN.
- DRAIN, 1 cycle: the final `mac_en` (for k=M-1) is issued. Next state is OUTPUT with lane index s=0.
- OUTPUT: `out_valid`=1, `out_sel`=s. On each out_ready handshake, s increments. On the handshake for s=P-1:
  - if g<N/P-1: g increments and the state returns to COMPUTE;
  - otherwise: g←0 and the state goes to LOAD.
- `mac_en`/`mac_clr` are 0 outside the delayed COMPUTE/DRAIN window. The accumulators therefore hold their values throughout OUTPUT.
- `in_ready`=0 outside LOAD. Vector load never overlaps with compute.
- Reset (asynchronous, any state): state→IDLE, counters k, g, s →0, strobe delay flops →0. A partially loaded vector or partially emitted group is discarded.

## Timing
- Reset value of every output: 0.
- `in_ready`, `out_valid`, `out_sel`, `x_addr`, and `w_addr` decode from registered state/counters; there is no combinational path from in_valid/out_ready to any output except `x_wr_en`.
- Last input accepted at edge L → COMPUTE in cycles L+1..L+M → DRAIN at L+M+1 → first `out_valid` at L+M+2.
- Between groups: the last out handshake at edge E is followed by COMPUTE from E+1. Per group, the cost is M+1 cycles plus P handshakes.
- out_valid held with out_ready=0: the state, `out_sel`, and the accumulators are stable indefinitely.
- in_valid gaps in LOAD: k holds, and no write occurs.

## Structure
- `layer_ctrl_pkg`: `state_t` enum (IDLE, LOAD, COMPUTE, DRAIN, OUTPUT) and the width helper functions used for the address ports.
- Sub-module `wrap_counter` (param MAX; inputs `clk`, `reset`, `en`; outputs `count`, `last`): instantiated three times for k (MAX=M), g (MAX=N/P), and s (MAX=P).
- A 1-stage delay flop pair produces `mac_en`/`mac_clr` from the COMPUTE decode.

## Test plan
- M=4,N=8,P=1, in_valid/out_ready held 1; load x=1,2,3,4 with the datapath model's weights all 1 → eight outputs of 10. First out_valid exactly 6 cycles after the 4th input edge. w_addr runs 0..31 in order.
- Same config with random 50% in_valid/out_ready → identical 8 outputs; x_wr_en count = 4 per vector; no mac_en during LOAD/OUTPUT.
- M=4,N=8,P=2 → 4 groups × 2 outputs; out_sel toggles 0,1 per group; w_addr per group g = 4g..4g+3. mac_clr is high only on the first mac_en of each group.
- out_ready held 0 for 20 cycles in OUTPUT → out_valid stays 1, out_sel/w_addr/mac_en constant, and mac_en=0 for the whole stall.
- reset pulled low mid-COMPUTE (k=2, g=1) → all outputs 0 immediately. After release: IDLE for 1 cycle, then LOAD with in_ready=1 and x_addr=0. The next vector produces correct results.
- Back-to-back vectors: 3 vectors streamed → in_ready=0 from the 4th accept until the final out handshake of vector n; 24 results in order.
